select_scanner: RTL and testbench

Generates the one-hot 32-bit channel-select vector that drives the pulse look-up mux, stepping through the enabled channels with a programmable dwell time per channel. It sits directly upstream of the look-up stage. While a channel's select bit is stable it flags a sample point, so downstream logic can capture the mux output. It supports single-sweep and continuous scanning.

---
 rtl/select_scanner_if.sv | 28 ++
 rtl/select_scanner.sv | 189 ++++++++++++++++++
 tb/tb_select_scanner.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/select_scanner_if.sv
// Handshake and data bundle between a scan controller and the channel-select scanner.
// The master drives the control inputs. The slave returns the select vector and the status strobes.
interface select_scanner_if #(
    parameter int unsigned N_CH    = 32,
    parameter int unsigned IDX_W   = 5,
    parameter int unsigned DWELL_W = 16
);
    logic               start;
    logic               stop;
    logic               continuous;
    logic [N_CH-1:0]    ch_mask;
    logic [DWELL_W-1:0] dwell;
    logic [N_CH-1:0]    select;
    logic [IDX_W-1:0]   ch_idx;
    logic               busy;
    logic               sample;
    logic               done;

    modport master (
        output start, stop, continuous, ch_mask, dwell,
        input  select, ch_idx, busy, sample, done
    );

    modport slave (
        input  start, stop, continuous, ch_mask, dwell,
        output select, ch_idx, busy, sample, done
    );
endinterface

// File: rtl/select_scanner.sv
// Steps a one-hot channel select through the enabled channels, holding each one for a programmable dwell.
// It strobes sample on each channel's last dwell cycle and done at the end of every sweep.
module select_scanner #(
    parameter int unsigned N_CH    = 32,
    parameter int unsigned IDX_W   = 5,
    parameter int unsigned DWELL_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    select_scanner_if.slave  bus
);
    typedef enum logic {
        IDLE  = 1'b0,
        DWELL = 1'b1
    } state_t;

    state_t             state;
    state_t             state_n;

    logic [N_CH-1:0]    mask_q;
    logic [N_CH-1:0]    mask_n;
    logic [DWELL_W-1:0] reload_q;
    logic [DWELL_W-1:0] reload_n;
    logic [DWELL_W-1:0] cnt_q;
    logic [DWELL_W-1:0] cnt_n;
    logic               cont_q;
    logic               cont_n;
    logic [IDX_W-1:0]   cur_q;
    logic [IDX_W-1:0]   cur_n;

    logic [N_CH-1:0]    select_q;
    logic [N_CH-1:0]    select_n;
    logic [IDX_W-1:0]   ch_idx_q;
    logic [IDX_W-1:0]   ch_idx_n;
    logic               busy_q;
    logic               busy_n;
    logic               sample_q;
    logic               sample_n;
    logic               done_q;
    logic               done_n;

    logic [N_CH-1:0]    above;
    logic [N_CH-1:0]    higher;
    logic               has_higher;
    logic               start_ok;
    logic               wrap_ok;
    logic               last_cycle;
    logic [DWELL_W-1:0] dwell_reload;

    // Priority encoder: index of the lowest set bit, 0 when the vector is empty.
    function automatic logic [IDX_W-1:0] lowest_idx(input logic [N_CH-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = int'(N_CH) - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

    // Enabled channels strictly above the current one
    always_comb begin
        above = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            above[i] = (IDX_W'(i) > cur_q);
        end
    end

    assign higher       = mask_q & above;
    assign has_higher   = |higher;
    assign dwell_reload = (bus.dwell == '0) ? '0 : bus.dwell - DWELL_W'(1);
    assign start_ok     = bus.start && (|bus.ch_mask);
    assign wrap_ok      = cont_q && (|bus.ch_mask);
    assign last_cycle   = (cnt_q == '0);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic; stop overrides everything but reset
    always_comb begin
        state_n = state;
        if (bus.stop) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        state_n = DWELL;
                    end
                end
                DWELL: begin
                    if (last_cycle && !has_higher && !wrap_ok) begin
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Datapath and next values of the registered outputs
    always_comb begin
        mask_n   = mask_q;
        reload_n = reload_q;
        cont_n   = cont_q;
        cur_n    = cur_q;
        cnt_n    = cnt_q;
        done_n   = 1'b0;
        select_n = '0;
        ch_idx_n = '0;
        busy_n   = 1'b0;
        sample_n = 1'b0;

        case (state)
            IDLE: begin
                if (start_ok && !bus.stop) begin
                    mask_n   = bus.ch_mask;
                    reload_n = dwell_reload;
                    cont_n   = bus.continuous;
                    cur_n    = lowest_idx(bus.ch_mask);
                    cnt_n    = dwell_reload;
                end
            end
            DWELL: begin
                if (!last_cycle) begin
                    cnt_n = cnt_q - DWELL_W'(1);
                end else if (has_higher) begin
                    cur_n = lowest_idx(higher);
                    cnt_n = reload_q;
                end else begin
                    done_n = !bus.stop;
                    if (wrap_ok) begin
                        mask_n = bus.ch_mask;
                        cur_n  = lowest_idx(bus.ch_mask);
                        cnt_n  = reload_q;
                    end
                end
            end
            default: ;
        endcase

        if (state_n == DWELL) begin
            select_n = N_CH'(1) << cur_n;
            ch_idx_n = cur_n;
            busy_n   = 1'b1;
            sample_n = (cnt_n == '0);
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q   <= '0;
            reload_q <= '0;
            cnt_q    <= '0;
            cont_q   <= 1'b0;
            cur_q    <= '0;
            select_q <= '0;
            ch_idx_q <= '0;
            busy_q   <= 1'b0;
            sample_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            mask_q   <= mask_n;
            reload_q <= reload_n;
            cnt_q    <= cnt_n;
            cont_q   <= cont_n;
            cur_q    <= cur_n;
            select_q <= select_n;
            ch_idx_q <= ch_idx_n;
            busy_q   <= busy_n;
            sample_q <= sample_n;
            done_q   <= done_n;
        end
    end

    assign bus.select = select_q;
    assign bus.ch_idx = ch_idx_q;
    assign bus.busy   = busy_q;
    assign bus.sample = sample_q;
    assign bus.done   = done_q;
endmodule

// File: tb/tb_select_scanner.sv
// Bench for select_scanner: directed sequences with literal expectations, then random traffic.
// A queue-based model of per-cycle dwell slots is checked against the DUT on every cycle.
module tb_select_scanner;
    localparam int unsigned N_CH    = 32;
    localparam int unsigned IDX_W   = 5;
    localparam int unsigned DWELL_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    select_scanner_if #(.N_CH(N_CH), .IDX_W(IDX_W), .DWELL_W(DWELL_W)) bus ();

    select_scanner #(.N_CH(N_CH), .IDX_W(IDX_W), .DWELL_W(DWELL_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Each queue entry is one dwell cycle still to be shown: the channel number and whether it is the sample cycle.
    int          plan_ch[$];
    bit          plan_smp[$];
    bit          m_active = 1'b0;
    bit          m_cont   = 1'b0;
    int          m_dwell  = 1;
    logic [31:0] exp_select = '0;
    logic [4:0]  exp_idx    = '0;
    bit          exp_busy   = 1'b0;
    bit          exp_sample = 1'b0;
    bit          exp_done   = 1'b0;

    function automatic void build(input logic [31:0] mask);
        for (int ch = 0; ch < 32; ch++) begin
            if (mask[ch]) begin
                for (int d = 0; d < m_dwell; d++) begin
                    plan_ch.push_back(ch);
                    plan_smp.push_back(d == m_dwell - 1);
                end
            end
        end
    endfunction

    // Model: inputs sampled at the edge, expectations for the following cycle
    always @(posedge clk) begin
        exp_done = 1'b0;
        if (rst || bus.stop) begin
            plan_ch.delete();
            plan_smp.delete();
            m_active = 1'b0;
        end else if (!m_active) begin
            if (bus.start && bus.ch_mask != 0) begin
                m_cont   = bus.continuous;
                m_dwell  = (bus.dwell == 0) ? 1 : int'(bus.dwell);
                build(bus.ch_mask);
                m_active = 1'b1;
            end
        end else begin
            void'(plan_ch.pop_front());
            void'(plan_smp.pop_front());
            if (plan_ch.size() == 0) begin
                exp_done = 1'b1;
                if (m_cont && bus.ch_mask != 0) begin
                    build(bus.ch_mask);
                end else begin
                    m_active = 1'b0;
                end
            end
        end
        if (m_active) begin
            exp_select = 32'd1 << plan_ch[0];
            exp_idx    = 5'(plan_ch[0]);
            exp_busy   = 1'b1;
            exp_sample = plan_smp[0];
        end else begin
            exp_select = '0;
            exp_idx    = '0;
            exp_busy   = 1'b0;
            exp_sample = 1'b0;
        end
    end

    // Compare against the model and check the invariants every cycle
    always @(negedge clk) begin
        bit idx_ok;
        check("select", bus.select, exp_select);
        check("ch_idx", 32'(bus.ch_idx), 32'(exp_idx));
        check("busy", 32'(bus.busy), 32'(exp_busy));
        check("sample", 32'(bus.sample), 32'(exp_sample));
        check("done", 32'(bus.done), 32'(exp_done));
        idx_ok = (bus.select == 0) ? (bus.ch_idx == 0) : (bus.select == (32'd1 << bus.ch_idx));
        check("onehot0", 32'($onehot0(bus.select)), 32'd1);
        check("idx_match", 32'(idx_ok), 32'd1);
        check("sample_busy", 32'(!(bus.sample && !bus.busy)), 32'd1);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Literal expectation for the current cycle, then advance one cycle
    task automatic lit(input string tag, input logic [31:0] sel, input bit smp, input bit dn, input bit bsy);
        @(negedge clk);
        check({tag, "_sel"}, bus.select, sel);
        check({tag, "_sample"}, 32'(bus.sample), 32'(smp));
        check({tag, "_done"}, 32'(bus.done), 32'(dn));
        check({tag, "_busy"}, 32'(bus.busy), 32'(bsy));
        tick();
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.stop       = 1'b0;
        bus.continuous = 1'b0;
        bus.ch_mask    = '0;
        bus.dwell      = '0;
        repeat (3) tick();
        lit("reset", 32'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();

        // Single sweep over channels 1..4, dwell 10; start and input changes while busy must not disturb it
        bus.ch_mask = 32'h0000_001E;
        bus.dwell   = 16'd10;
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            lit("sweep", 32'h2 << ((c - 1) / 10), (c % 10) == 0, 1'b0, 1'b1);
            if (c == 5) begin
                bus.start   = 1'b1;
                bus.ch_mask = 32'hFFFF_FFFF;
                bus.dwell   = 16'd3;
            end
            if (c == 6) begin
                bus.start = 1'b0;
            end
        end
        lit("sweep_end", 32'h0, 1'b0, 1'b1, 1'b0);
        lit("sweep_idle", 32'h0, 1'b0, 1'b0, 1'b0);

        // Dwell 0 on a sparse mask
        bus.ch_mask = 32'h8000_0001;
        bus.dwell   = 16'd0;
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;
        lit("d0_a", 32'h0000_0001, 1'b1, 1'b0, 1'b1);
        lit("d0_b", 32'h8000_0000, 1'b1, 1'b0, 1'b1);
        lit("d0_end", 32'h0, 1'b0, 1'b1, 1'b0);

        // Continuous with a mask update mid-sweep
        bus.ch_mask    = 32'h0000_0003;
        bus.dwell      = 16'd2;
        bus.continuous = 1'b1;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        lit("cont1", 32'h1, 1'b0, 1'b0, 1'b1);
        bus.ch_mask = 32'h0000_0004;
        lit("cont2", 32'h1, 1'b1, 1'b0, 1'b1);
        lit("cont3", 32'h2, 1'b0, 1'b0, 1'b1);
        lit("cont4", 32'h2, 1'b1, 1'b0, 1'b1);
        lit("cont5", 32'h4, 1'b0, 1'b1, 1'b1);
        lit("cont6", 32'h4, 1'b1, 1'b0, 1'b1);
        lit("cont7", 32'h4, 1'b0, 1'b1, 1'b1);
        lit("cont8", 32'h4, 1'b1, 1'b0, 1'b1);
        bus.stop = 1'b1;
        tick();
        bus.stop       = 1'b0;
        bus.continuous = 1'b0;
        lit("cont_stop", 32'h0, 1'b0, 1'b0, 1'b0);

        // Stop while dwelling on channel 3
        bus.ch_mask = 32'h0000_0018;
        bus.dwell   = 16'd8;
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;
        lit("stop1", 32'h8, 1'b0, 1'b0, 1'b1);
        lit("stop2", 32'h8, 1'b0, 1'b0, 1'b1);
        bus.stop = 1'b1;
        lit("stop3", 32'h8, 1'b0, 1'b0, 1'b1);
        bus.stop = 1'b0;
        lit("stop4", 32'h0, 1'b0, 1'b0, 1'b0);
        lit("stop5", 32'h0, 1'b0, 1'b0, 1'b0);

        // Start with an empty mask, then start and stop together
        bus.ch_mask = 32'h0;
        bus.start   = 1'b1;
        lit("empty_pre", 32'h0, 1'b0, 1'b0, 1'b0);
        bus.start = 1'b0;
        lit("empty_post", 32'h0, 1'b0, 1'b0, 1'b0);
        bus.ch_mask = 32'h1;
        bus.start   = 1'b1;
        bus.stop    = 1'b1;
        lit("both_pre", 32'h0, 1'b0, 1'b0, 1'b0);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        lit("both_post", 32'h0, 1'b0, 1'b0, 1'b0);

        // Reset during a long continuous scan, then a fresh start
        bus.ch_mask    = 32'h0000_0050;
        bus.dwell      = 16'd100;
        bus.continuous = 1'b1;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (150) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        lit("rst_out", 32'h0, 1'b0, 1'b0, 1'b0);
        bus.continuous = 1'b0;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        lit("rst_c1", 32'h10, 1'b0, 1'b0, 1'b1);
        repeat (98) tick();
        lit("rst_c100", 32'h10, 1'b1, 1'b0, 1'b1);
        lit("rst_c101", 32'h40, 1'b0, 1'b0, 1'b1);
        repeat (110) tick();

        // Random traffic against the model
        for (int n = 0; n < 4000; n++) begin
            bus.start      = ($urandom % 6) == 0;
            bus.stop       = ($urandom % 80) == 0;
            bus.continuous = $urandom % 2;
            case ($urandom % 5)
                0:       bus.ch_mask = 32'h0;
                1:       bus.ch_mask = 32'd1 << ($urandom % 32);
                2:       bus.ch_mask = $urandom & $urandom & $urandom;
                default: bus.ch_mask = $urandom;
            endcase
            bus.dwell = 16'($urandom % 5);
            rst       = ($urandom % 600) == 0;
            tick();
        end
        rst       = 1'b0;
        bus.start = 1'b0;
        bus.stop  = 1'b1;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
